mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single SRAM controller port between the IF stage (instruction reads) and the MEM stage (data reads/writes) of the MIPS pipeline. It sits between those two stage ports and the SRAM controller. It grants one requester at a time, holds the controller command stable until the controller signals completion, and returns registered read data plus a one-cycle ready pulse to the owner. The pipeline freezes a stage while that stage's request is pending and its ready has not yet pulsed.

## Interface
- MAX_MEM_STREAK, 4: consecutive MEM grants allowed while IF waits (used only with fairness enabled); range 1..15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request; held until if_ready.
- if_addr  in  32  IF byte address; stable while if_req.
- if_rdata  out  32  instruction word; valid in the if_ready cycle.
- if_ready  out  1  one-cycle completion pulse to IF.
- mem_rd_req  in  1  MEM read request; held until mem_ready.
- mem_wr_req  in  1  MEM write request; held until mem_ready.
- mem_addr  in  32  MEM byte address.
- mem_wdata  in  32  MEM write data.
- mem_rdata  out  32  load data; valid in the mem_ready cycle.
- mem_ready  out  1  one-cycle completion pulse to MEM.
- ctrl_rd_en  out  1  read command to the SRAM controller.
- ctrl_wr_en  out  1  write command to the SRAM controller.
- ctrl_addr  out  32  address to the controller.
- ctrl_wdata  out  32  write data to the controller.
- ctrl_rdata  in  32  controller read data; valid with ctrl_ready.
- ctrl_ready  in  1  controller completion pulse.

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, DONE.
- IDLE: if any MEM request is present, go to BUSY_MEM; else if if_req is present, go to BUSY_IF; else stay in IDLE. MEM has priority because it belongs to the older instruction.
- On grant, latch the owner's addr, wdata and read/write kind into the command registers.
- BUSY_*: ctrl_rd_en or ctrl_wr_en, ctrl_addr and ctrl_wdata are driven from the command registers and held constant. On ctrl_ready, capture ctrl_rdata into the owner's rdata register (reads only), then go to DONE.
- DONE: the owner's ready is high for exactly one cycle. Requests are ignored in this cycle, which prevents double service of a request that has not dropped yet. Next state is IDLE.
- If mem_rd_req and mem_wr_req are both high, the write is serviced and the read is ignored.
- Requests that drop while not granted are simply not serviced. Dropping a request after its grant has no effect: the transaction completes.
- ctrl_ready outside BUSY_* is ignored.
- Reset values: state IDLE; all ready outputs and ctrl_*_en outputs 0; ctrl_addr, ctrl_wdata, if_rdata and mem_rdata 0; streak counter 0.
- Reset mid-transaction abandons the transaction with no ready pulse. The SRAM controller shares rst.

## Timing
- Grant latency: a request seen in IDLE at edge N puts the command on ctrl_* from cycle N+1.
- Completion: ctrl_ready in cycle M gives owner ready and rdata in cycle M+1, and IDLE in cycle M+2.
- Minimum turnaround per transaction is 3 cycles plus the controller latency.
- if_rdata and mem_rdata hold their value until the next read for that port completes.

## Configuration
- MEM_ARB_FAIRNESS_EN defined:
  - A 4-bit streak counter increments on each MEM grant made while if_req is high.
  - The counter clears on any IF grant and whenever if_req is low at a grant decision.
  - When the counter equals MAX_MEM_STREAK and if_req is high, IF wins the next IDLE decision even if MEM is requesting.
- MEM_ARB_FAIRNESS_EN undefined: strict MEM priority; no counter logic is built.

## Structure
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE=2'd0, BUSY_IF=2'd1, BUSY_MEM=2'd2, DONE=2'd3);
  - owner encoding (OWNER_IF, OWNER_MEM);
  - STREAK_W=4.
- Sub-module grant_streak_counter, instantiated only under MEM_ARB_FAIRNESS_EN. Ports: clk, rst, inc, clr; output at_limit.

## Test plan
- IF-only read: if_req=1, if_addr=0x40, controller returns 0x8C010004 after 5 cycles. Expect ctrl_rd_en high for 5 cycles, then if_ready pulses once with if_rdata=0x8C010004, and no second transaction while if_req is still high in the DONE cycle.
- Simultaneous requests: if_req and mem_wr_req rise together, mem_addr=0x100, mem_wdata=0xDEADBEEF. Expect ctrl_wr_en with addr 0x100 first, mem_ready, then the IF read is granted 2 cycles later.
- Read/write conflict: mem_rd_req=mem_wr_req=1. Expect only ctrl_wr_en, one mem_ready, and mem_rdata unchanged.
- Reset mid-transaction: assert rst one cycle into BUSY_MEM. Expect all outputs 0 the next cycle, no mem_ready pulse, and a stray ctrl_ready afterwards ignored.
- Fairness (macro defined, MAX_MEM_STREAK=2): mem_rd_req and if_req held continuously. Expect grant order MEM, MEM, IF, MEM, MEM, IF. Without the macro, expect IF never granted until MEM drops.
- Stability: change if_addr during BUSY_IF. Expect ctrl_addr to keep the latched value.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/MEM SRAM port arbiter.
package mem_arb_pkg;

    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_streak.sv
// Counts consecutive MEM grants made while IF is waiting; at_limit is combinational from the count.
// Latency: count updates on the edge after inc/clr. No backpressure; clr wins over inc, saturates at all-ones.
module grant_streak_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STREAK_W-1:0] LIM = STREAK_W'(LIMIT);

    logic [STREAK_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM controller port between IF reads and MEM reads/writes; MEM_ARB_FAIRNESS_EN adds an IF anti-starvation streak limit.
// Latency: command on ctrl_* one cycle after grant; owner ready/rdata one cycle after ctrl_ready, IDLE the cycle after.
// Backpressure: requesters are held (stalled) until their one-cycle ready pulse; the DONE cycle ignores all requests.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_rd_req,
    input  logic        mem_wr_req,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        ctrl_rd_en,
    output logic        ctrl_wr_en,
    output logic [31:0] ctrl_addr,
    output logic [31:0] ctrl_wdata,
    input  logic [31:0] ctrl_rdata,
    input  logic        ctrl_ready
);

    arb_state_t  state, state_nxt;
    owner_t      owner;
    logic        cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [31:0] if_rdata_q, mem_rdata_q;
    logic        mem_any, decide, if_forced, grant_mem, grant_if, busy;

    assign mem_any = mem_rd_req | mem_wr_req;
    assign decide  = (state == IDLE) && (mem_any || if_req);
    assign busy    = (state == BUSY_IF) || (state == BUSY_MEM);

`ifdef MEM_ARB_FAIRNESS_EN
    logic at_limit;

    // A decision with IF absent breaks the streak; only MEM wins over a waiting IF extend it.
    grant_streak_counter #(.LIMIT(MAX_MEM_STREAK)) u_streak (
        .clk      (clk),
        .rst      (rst),
        .inc      (grant_mem && if_req),
        .clr      (grant_if || (decide && !if_req)),
        .at_limit (at_limit)
    );

    assign if_forced = at_limit && if_req;
`else
    logic unused_streak_cfg;
    assign unused_streak_cfg = (MAX_MEM_STREAK != 0);
    assign if_forced         = 1'b0;
`endif

    // MEM belongs to the older instruction, so it wins unless IF has waited too long.
    assign grant_mem = decide && mem_any && !if_forced;
    assign grant_if  = decide && !grant_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_mem) begin
                    state_nxt = BUSY_MEM;
                end else if (grant_if) begin
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (ctrl_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= OWNER_IF;
            cmd_wr      <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if (grant_mem) begin
                owner     <= OWNER_MEM;
                cmd_wr    <= mem_wr_req;
                cmd_addr  <= mem_addr;
                cmd_wdata <= mem_wdata;
            end else if (grant_if) begin
                owner     <= OWNER_IF;
                cmd_wr    <= 1'b0;
                cmd_addr  <= if_addr;
                cmd_wdata <= '0;
            end
            if (busy && ctrl_ready && !cmd_wr) begin
                if (owner == OWNER_IF) begin
                    if_rdata_q <= ctrl_rdata;
                end else begin
                    mem_rdata_q <= ctrl_rdata;
                end
            end
        end
    end

    always_comb begin
        ctrl_rd_en = busy && !cmd_wr;
        ctrl_wr_en = busy && cmd_wr;
        ctrl_addr  = cmd_addr;
        ctrl_wdata = cmd_wdata;
        if_ready   = (state == DONE) && (owner == OWNER_IF);
        mem_ready  = (state == DONE) && (owner == OWNER_MEM);
        if_rdata   = if_rdata_q;
        mem_rdata  = mem_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expectations follow MEM_ARB_FAIRNESS_EN when defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ctrl_rd_en;
    logic        ctrl_wr_en;
    logic [31:0] ctrl_addr;
    logic [31:0] ctrl_wdata;
    logic [31:0] ctrl_rdata;
    logic        ctrl_ready;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.MAX_MEM_STREAK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .ctrl_rd_en (ctrl_rd_en),
        .ctrl_wr_en (ctrl_wr_en),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_rdata (ctrl_rdata),
        .ctrl_ready (ctrl_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the first busy cycle; returns in the DONE cycle.
    task automatic respond(input int lat, input logic [31:0] data, input string name);
        int n;
        n = 0;
        for (int i = 1; i <= lat; i++) begin
            if (ctrl_rd_en || ctrl_wr_en) n++;
            if (i == lat) begin
                ctrl_rdata = data;
                ctrl_ready = 1'b1;
            end
            step();
        end
        ctrl_ready = 1'b0;
        ctrl_rdata = 32'h0;
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s cmd_cycles got %0d want %0d", name, n, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 0; if_addr = 0; mem_rd_req = 0; mem_wr_req = 0;
        mem_addr = 0; mem_wdata = 0; ctrl_rdata = 0; ctrl_ready = 0;
        repeat (3) step();
        checks++;
        if ({ctrl_rd_en, ctrl_wr_en, if_ready, mem_ready} !== 4'b0000 ||
            ctrl_addr !== 32'h0 || ctrl_wdata !== 32'h0 || if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b%b rdy=%b%b addr=%h wd=%h ir=%h mr=%h want all zero",
                     ctrl_rd_en, ctrl_wr_en, if_ready, mem_ready, ctrl_addr, ctrl_wdata, if_rdata, mem_rdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_if_only();
        if_req = 1; if_addr = 32'h40;
        step();
        checks++;
        if (ctrl_rd_en !== 1'b1 || ctrl_wr_en !== 1'b0 || ctrl_addr !== 32'h40) begin
            errors++;
            $display("FAIL if_grant got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=00000040", ctrl_rd_en, ctrl_wr_en, ctrl_addr);
        end
        respond(5, 32'h8C010004, "if_only");
        checks++;
        if (if_ready !== 1'b1 || mem_ready !== 1'b0 || if_rdata !== 32'h8C010004 || ctrl_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL if_done got ir=%b mr=%b data=%h rd=%b want 1 0 8c010004 0", if_ready, mem_ready, if_rdata, ctrl_rd_en);
        end
        step();
        checks++;
        if (if_ready !== 1'b0 || ctrl_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL if_no_double got ir=%b rd=%b want 0 0", if_ready, ctrl_rd_en);
        end
        if_req = 0;
        step();
    endtask

    task automatic test_simultaneous_and_stability();
        if_req = 1; if_addr = 32'h80;
        mem_wr_req = 1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF;
        step();
        checks++;
        if (ctrl_wr_en !== 1'b1 || ctrl_rd_en !== 1'b0 || ctrl_addr !== 32'h100 || ctrl_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sim_mem_first got wr=%b rd=%b addr=%h wd=%h want 1 0 00000100 deadbeef",
                     ctrl_wr_en, ctrl_rd_en, ctrl_addr, ctrl_wdata);
        end
        respond(2, 32'h0, "sim_write");
        checks++;
        if (mem_ready !== 1'b1 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL sim_mem_ready got mr=%b ir=%b want 1 0", mem_ready, if_ready);
        end
        mem_wr_req = 0;
        step();
        checks++;
        if (ctrl_rd_en !== 1'b0 || ctrl_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL sim_idle got rd=%b wr=%b want 0 0", ctrl_rd_en, ctrl_wr_en);
        end
        step();
        checks++;
        if (ctrl_rd_en !== 1'b1 || ctrl_addr !== 32'h80) begin
            errors++;
            $display("FAIL sim_if_second got rd=%b addr=%h want 1 00000080", ctrl_rd_en, ctrl_addr);
        end
        if_addr = 32'h1234;
        step();
        checks++;
        if (ctrl_addr !== 32'h80 || ctrl_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL addr_stable got addr=%h rd=%b want 00000080 1", ctrl_addr, ctrl_rd_en);
        end
        respond(2, 32'h11112222, "sim_read");
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h11112222) begin
            errors++;
            $display("FAIL sim_if_data got ir=%b data=%h want 1 11112222", if_ready, if_rdata);
        end
        if_req = 0;
        step();
    endtask

    task automatic test_rw_conflict();
        mem_rd_req = 1; mem_addr = 32'h200;
        step();
        respond(1, 32'hCAFEF00D, "mem_read");
        checks++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'hCAFEF00D || if_rdata !== 32'h11112222) begin
            errors++;
            $display("FAIL mem_read got mr=%b data=%h if_data=%h want 1 cafef00d 11112222", mem_ready, mem_rdata, if_rdata);
        end
        mem_rd_req = 0;
        step();
        mem_rd_req = 1; mem_wr_req = 1; mem_addr = 32'h204; mem_wdata = 32'h55AA55AA;
        step();
        checks++;
        if (ctrl_wr_en !== 1'b1 || ctrl_rd_en !== 1'b0 || ctrl_wdata !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL rw_write_wins got wr=%b rd=%b wd=%h want 1 0 55aa55aa", ctrl_wr_en, ctrl_rd_en, ctrl_wdata);
        end
        respond(1, 32'h99999999, "rw_conflict");
        checks++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rw_rdata_kept got mr=%b data=%h want 1 cafef00d", mem_ready, mem_rdata);
        end
        mem_rd_req = 0; mem_wr_req = 0;
        step();
        checks++;
        if (mem_ready !== 1'b0 || ctrl_wr_en !== 1'b0 || ctrl_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL rw_single_pulse got mr=%b wr=%b rd=%b want 0 0 0", mem_ready, ctrl_wr_en, ctrl_rd_en);
        end
    endtask

    task automatic test_reset_mid();
        mem_rd_req = 1; mem_addr = 32'h300;
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({ctrl_rd_en, ctrl_wr_en, if_ready, mem_ready} !== 4'b0000 || ctrl_addr !== 32'h0 ||
            ctrl_wdata !== 32'h0 || if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got en=%b%b rdy=%b%b addr=%h wd=%h ir=%h mr=%h want all zero",
                     ctrl_rd_en, ctrl_wr_en, if_ready, mem_ready, ctrl_addr, ctrl_wdata, if_rdata, mem_rdata);
        end
        rst = 1'b0; mem_rd_req = 0;
        ctrl_ready = 1'b1; ctrl_rdata = 32'h77777777;
        step();
        ctrl_ready = 1'b0; ctrl_rdata = 32'h0;
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || ctrl_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL stray_ready got mr=%b data=%h rd=%b want 0 0 0", mem_ready, mem_rdata, ctrl_rd_en);
        end
        step();
        checks++;
        if (mem_ready !== 1'b0 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL stray_no_pulse got mr=%b ir=%b want 0 0", mem_ready, if_ready);
        end
    endtask

    task automatic test_fairness();
        logic exp_mem [6];
        logic got_mem;
        int   wait_n;
`ifdef MEM_ARB_FAIRNESS_EN
        exp_mem = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        exp_mem = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        mem_rd_req = 1; mem_addr = 32'h400;
        if_req = 1; if_addr = 32'h500;
        for (int t = 0; t < 6; t++) begin
            wait_n = 0;
            step();
            while (!(ctrl_rd_en || ctrl_wr_en) && wait_n < 8) begin
                step();
                wait_n++;
            end
            got_mem = (ctrl_addr == 32'h400);
            checks++;
            if (wait_n >= 8 || got_mem !== exp_mem[t]) begin
                errors++;
                $display("FAIL fair_grant_%0d got mem=%b addr=%h waited=%0d want mem=%b", t, got_mem, ctrl_addr, wait_n, exp_mem[t]);
            end
            respond(1, 32'hA0000000 + 32'(t), "fair_txn");
        end
        mem_rd_req = 0;
        step();
        step();
        checks++;
        if (ctrl_rd_en !== 1'b1 || ctrl_addr !== 32'h500) begin
            errors++;
            $display("FAIL fair_if_after_drop got rd=%b addr=%h want 1 00000500", ctrl_rd_en, ctrl_addr);
        end
        respond(1, 32'hBEEF0001, "fair_if");
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'hBEEF0001) begin
            errors++;
            $display("FAIL fair_if_data got ir=%b data=%h want 1 beef0001", if_ready, if_rdata);
        end
        if_req = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_simultaneous_and_stability();
        test_rw_conflict();
        test_reset_mid();
        test_fairness();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
